cog_muldiv: RTL and testbench

- Iterative multiply/divide unit for the cog execution stage, sitting beside the single-cycle ALU.
- Removes the combinational 32x32 multiplier path and adds division.
- Parametrised in operand width and radix (bits retired per clock).
- Start/busy/done handshake; fixed latency, so the cog sequencer can stall deterministically.

---
 rtl/cog_muldiv_if.sv | 26 ++
 rtl/cog_muldiv.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cog_muldiv.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cog_muldiv_if.sv
// cog_muldiv_if: request/result bundle between the cog sequencer and the
// iterative multiply/divide unit. The sequencer drives the master side.
interface cog_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] s;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             co;
    logic             zo;

    modport master (
        output start, op, d, s,
        input  busy, done, r_lo, r_hi, co, zo
    );

    modport slave (
        input  start, op, d, s,
        output busy, done, r_lo, r_hi, co, zo
    );
endinterface

// File: rtl/cog_muldiv.sv
// cog_muldiv: iterative multiply/divide unit for the cog execution stage.
// Sequence IDLE -> PREP -> ITER (WIDTH/STEPS_PER_CLK cycles) -> FIX -> IDLE,
// so done always rises WIDTH/STEPS_PER_CLK + 2 edges after start is taken.
// Ops: 000 mul, 001 muls, 010 div, 011 divs. Defining COG_MULDIV_SQRT_EN
// adds 100 = unsigned integer square root of d; without it op[2] is ignored.
// WIDTH must be even and >= 8; STEPS_PER_CLK is 1, 2 or 4 and divides WIDTH.
module cog_muldiv #(
    parameter int WIDTH         = 32,
    parameter int STEPS_PER_CLK = 1
) (
    input  logic        clk_cog,
    input  logic        nres,
    cog_muldiv_if.slave bus
);

    localparam int N     = WIDTH / STEPS_PER_CLK;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // control state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // captured request
    logic [1:0]       op_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] s_q;

    // iteration datapath
    logic             neg_q;    // quotient / product must be negated
    logic             neg_rem;  // remainder takes the dividend's sign
    logic [WIDTH-1:0] a_reg;    // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] b_reg;    // multiplier shifting out MSB-first, or divisor
    logic [2*WIDTH-1:0] acc;    // product accumulator
    logic [WIDTH-1:0] rem;      // partial remainder

    // registered results
    logic             done_r;
    logic [WIDTH-1:0] r_lo_r;
    logic [WIDTH-1:0] r_hi_r;
    logic             co_r;
    logic             zo_r;

    // op decode
    logic signed_op;
    logic div_op;
    logic a_neg;
    logic b_neg;

`ifdef COG_MULDIV_SQRT_EN
    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 5;  // headroom for the signed non-restoring remainder
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N / 2);

    logic          sqrt_q;
    logic [HW-1:0] sq_root;
    logic [HW-1:0] sq_root_nx;
    logic [RW-1:0] sq_rem;
    logic [RW-1:0] sq_rem_nx;
    logic [RW-1:0] sq_rem_fix;
    logic [RW-1:0] sq_t;
    logic [WIDTH-1:0] sq_x_nx;

    assign signed_op = op_q[0] & ~sqrt_q;
`else
    assign signed_op = op_q[0];
`endif
    assign div_op = op_q[1];
    assign a_neg  = signed_op & d_q[WIDTH-1];
    assign b_neg  = signed_op & s_q[WIDTH-1];

    // Magnitude is formed one bit wider so the most-negative operand negates
    // exactly; its magnitude 2^(WIDTH-1) still fits the unsigned WIDTH result.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        logic [WIDTH:0] ext;
        ext = {neg, v};
        if (neg) ext = -ext;
        return ext[WIDTH-1:0];
    endfunction

    logic [2*WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0]   mul_b_nx;
    logic [WIDTH-1:0]   div_q_nx;
    logic [WIDTH-1:0]   div_rem_nx;
    logic [WIDTH:0]     div_t;

    // One iteration of shift-add multiply and restoring divide, STEPS_PER_CLK bits deep.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        mul_acc_nx = acc;
        mul_b_nx   = b_reg;
        div_q_nx   = a_reg;
        div_rem_nx = rem;
        div_t      = '0;
        for (int k = 0; k < STEPS_PER_CLK; k++) begin
            mul_acc_nx = {mul_acc_nx[2*WIDTH-2:0], 1'b0};
            if (mul_b_nx[WIDTH-1]) mul_acc_nx = mul_acc_nx + {{WIDTH{1'b0}}, a_reg};
            mul_b_nx = {mul_b_nx[WIDTH-2:0], 1'b0};

            div_t    = {div_rem_nx, div_q_nx[WIDTH-1]};
            div_q_nx = {div_q_nx[WIDTH-2:0], 1'b0};
            if (div_t >= {1'b0, b_reg}) begin
                div_t       = div_t - {1'b0, b_reg};
                div_q_nx[0] = 1'b1;
            end
            div_rem_nx = div_t[WIDTH-1:0];
        end
    end

`ifdef COG_MULDIV_SQRT_EN
    // Non-restoring root, two radicand bits per step; active in the last N/2 ITER cycles.
    always_comb begin
        sq_root_nx = sq_root;
        sq_rem_nx  = sq_rem;
        sq_x_nx    = a_reg;
        sq_t       = '0;
        if (cnt < CNT_HALF) begin
            for (int k = 0; k < STEPS_PER_CLK; k++) begin
                sq_t    = {sq_rem_nx[RW-3:0], sq_x_nx[WIDTH-1:WIDTH-2]};
                sq_x_nx = {sq_x_nx[WIDTH-3:0], 2'b00};
                if (sq_rem_nx[RW-1]) sq_t = sq_t + RW'({sq_root_nx, 2'b11});
                else                 sq_t = sq_t - RW'({sq_root_nx, 2'b01});
                sq_rem_nx  = sq_t;
                sq_root_nx = {sq_root_nx[HW-2:0], ~sq_t[RW-1]};
            end
        end
        sq_rem_fix = sq_rem[RW-1] ? sq_rem + RW'({sq_root, 1'b1}) : sq_rem;
    end
`endif

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               res_co;
    logic               res_zo;

    // Sign correction, special divide cases and flag generation for FIX.
    always_comb begin
        prod   = neg_q   ? -acc   : acc;
        quo    = neg_q   ? -a_reg : a_reg;
        rmd    = neg_rem ? -rem   : rem;
        res_lo = prod[WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_co = 1'b0;
        res_zo = 1'b0;
`ifdef COG_MULDIV_SQRT_EN
        if (sqrt_q) begin
            res_lo = WIDTH'(sq_root);
            res_hi = WIDTH'(sq_rem_fix);
            res_zo = (d_q == '0);
        end else
`endif
        if (div_op) begin
            if (s_q == '0) begin
                res_lo = '1;
                res_hi = d_q;
                res_co = 1'b1;
            end else if (signed_op && d_q == {1'b1, {(WIDTH-1){1'b0}}} && s_q == '1) begin
                res_lo = d_q;
                res_hi = '0;
                res_co = 1'b1;
            end else begin
                res_lo = quo;
                res_hi = rmd;
            end
            res_zo = (res_lo == '0);
        end else begin
            res_zo = (prod == '0);
            if (signed_op) res_co = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            else           res_co = (prod[2*WIDTH-1:WIDTH] != '0);
        end
    end

    // Sequencer, iteration counter and result registers; nres clears all of them.
    always_ff @(posedge clk_cog) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!nres) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            r_lo_r <= '0;
            r_hi_r <= '0;
            co_r   <= 1'b0;
            zo_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) state <= ST_PREP;
                ST_PREP: begin
                    state <= ST_ITER;
                    cnt   <= CNT_LAST;
                end
                ST_ITER: begin
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - CNT_ONE;
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    done_r <= 1'b1;
                    r_lo_r <= res_lo;
                    r_hi_r <= res_hi;
                    co_r   <= res_co;
                    zo_r   <= res_zo;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture, PREP set-up and per-cycle datapath advance.
    always_ff @(posedge clk_cog) begin
        // NOTE: datapath registers carry no reset; each op reloads them in
        // IDLE/PREP before they are read, and an abandoned op never reaches FIX.
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    op_q <= bus.op[1:0];
                    d_q  <= bus.d;
                    s_q  <= bus.s;
`ifdef COG_MULDIV_SQRT_EN
                    sqrt_q <= bus.op[2];
`endif
                end
            end
            ST_PREP: begin
                neg_q   <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                a_reg   <= magnitude(d_q, a_neg);
                b_reg   <= magnitude(s_q, b_neg);
                acc     <= '0;
                rem     <= '0;
`ifdef COG_MULDIV_SQRT_EN
                sq_root <= '0;
                sq_rem  <= '0;
`endif
            end
            ST_ITER: begin
`ifdef COG_MULDIV_SQRT_EN
                if (sqrt_q) begin
                    a_reg   <= sq_x_nx;
                    sq_root <= sq_root_nx;
                    sq_rem  <= sq_rem_nx;
                end else
`endif
                if (div_op) begin
                    a_reg <= div_q_nx;
                    rem   <= div_rem_nx;
                end else begin
                    acc   <= mul_acc_nx;
                    b_reg <= mul_b_nx;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state == ST_ITER) || (state == ST_FIX);
    assign bus.done = done_r;
    assign bus.r_lo = r_lo_r;
    assign bus.r_hi = r_hi_r;
    assign bus.co   = co_r;
    assign bus.zo   = zo_r;

endmodule

// File: tb/tb_cog_muldiv.sv
// tb_cog_muldiv: directed checks of cog_muldiv at radix 1 (dut_a) and radix 4
// (dut_b). Expected results are hand-computed constants.
module tb_cog_muldiv;

    localparam int W     = 32;
    localparam int LAT_A = W / 1 + 2;
    localparam int LAT_B = W / 4 + 2;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULS = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVS = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    logic clk_cog = 1'b0;
    logic nres;
    always #5 clk_cog = ~clk_cog;

    logic         sel_b;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] s;

    int tests_run    = 0;
    int tests_failed = 0;

    cog_muldiv_if #(.WIDTH(W)) bus_a ();
    cog_muldiv_if #(.WIDTH(W)) bus_b ();

    assign bus_a.start = start & ~sel_b;
    assign bus_b.start = start & sel_b;
    assign bus_a.op = op;
    assign bus_b.op = op;
    assign bus_a.d  = d;
    assign bus_b.d  = d;
    assign bus_a.s  = s;
    assign bus_b.s  = s;

    cog_muldiv #(.WIDTH(W), .STEPS_PER_CLK(1)) dut_a (
        .clk_cog (clk_cog),
        .nres    (nres),
        .bus     (bus_a)
    );

    cog_muldiv #(.WIDTH(W), .STEPS_PER_CLK(4)) dut_b (
        .clk_cog (clk_cog),
        .nres    (nres),
        .bus     (bus_b)
    );

    wire         busy_o = sel_b ? bus_b.busy : bus_a.busy;
    wire         done_o = sel_b ? bus_b.done : bus_a.done;
    wire [W-1:0] r_lo_o = sel_b ? bus_b.r_lo : bus_a.r_lo;
    wire [W-1:0] r_hi_o = sel_b ? bus_b.r_hi : bus_a.r_hi;
    wire         co_o   = sel_b ? bus_b.co   : bus_a.co;
    wire         zo_o   = sel_b ? bus_b.zo   : bus_a.zo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                             input logic e_co, input logic e_zo);
        check({tag, ".r_lo"}, 64'(r_lo_o), 64'(e_lo));
        check({tag, ".r_hi"}, 64'(r_hi_o), 64'(e_hi));
        check({tag, ".co"},   64'(co_o),   64'(e_co));
        check({tag, ".zo"},   64'(zo_o),   64'(e_zo));
    endtask

    // Present a request at the falling edge; returns 1 time unit after edge 0.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] dd, input logic [W-1:0] ss);
        @(negedge clk_cog);
        start = 1'b1;
        op    = o;
        d     = dd;
        s     = ss;
        @(posedge clk_cog);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded), and busy-high cycles on the way.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done_o !== 1'b1 && cyc < 100) begin
            @(posedge clk_cog);
            #1;
            cyc++;
            if (busy_o === 1'b1) bcnt++;
        end
    endtask

    task automatic run_op(input string tag, input bit use_b, input logic [2:0] o,
                          input logic [W-1:0] dd, input logic [W-1:0] ss,
                          input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                          input logic e_co, input logic e_zo);
        int cyc;
        int bcnt;
        sel_b = use_b;
        issue(o, dd, ss);
        wait_done(cyc, bcnt);
        check({tag, ".latency"}, 64'(cyc), use_b ? 64'(LAT_B) : 64'(LAT_A));
        check_res(tag, e_lo, e_hi, e_co, e_zo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bcnt;
        int dones;

        nres  = 1'b0;
        sel_b = 1'b0;
        start = 1'b0;
        op    = '0;
        d     = '0;
        s     = '0;
        repeat (3) @(posedge clk_cog);
        #1;
        check("rst_a.busy", 64'(busy_o), 64'(0));
        check("rst_a.done", 64'(done_o), 64'(0));
        check_res("rst_a", '0, '0, 1'b0, 1'b0);
        sel_b = 1'b1;
        check("rst_b.busy", 64'(busy_o), 64'(0));
        check_res("rst_b", '0, '0, 1'b0, 1'b0);
        sel_b = 1'b0;
        nres  = 1'b1;

        // full-range unsigned product: latency, busy width and done pulse width
        issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, bcnt);
        check("mul_max.latency", 64'(cyc), 64'(LAT_A));
        check("mul_max.busy_cycles", 64'(bcnt), 64'(33));
        check_res("mul_max", 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);
        @(posedge clk_cog);
        #1;
        check("mul_max.done_pulse", 64'(done_o), 64'(0));

        run_op("muls_neg",  1'b0, OP_MULS, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("muls_zero", 1'b0, OP_MULS, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
        run_op("muls_ovf",  1'b0, OP_MULS, 32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("divs_m7_2", 1'b0, OP_DIVS, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("divs_7_m2", 1'b0, OP_DIVS, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0);
        run_op("div_100_7", 1'b0, OP_DIV,  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0);
        run_op("div_5_7",   1'b0, OP_DIV,  32'd5,        32'd7,        32'd0,        32'd5,        1'b0, 1'b1);
        run_op("div_by_0",  1'b0, OP_DIV,  32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
        run_op("divs_ovf",  1'b0, OP_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0);

        // start re-pulsed with other operands mid-operation must be ignored
        issue(OP_MUL, 32'd6, 32'd7);
        repeat (10) @(posedge clk_cog);
        @(negedge clk_cog);
        start = 1'b1;
        op    = OP_DIV;
        d     = 32'd1;
        s     = 32'd1;
        @(posedge clk_cog);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("repulse.latency", 64'(cyc + 11), 64'(LAT_A));
        check_res("repulse", 32'd42, 32'd0, 1'b0, 1'b0);

        // start raised in the done cycle is accepted; outputs hold meanwhile
        check("b2b.done_seen", 64'(done_o), 64'(1));
        start = 1'b1;
        op    = OP_DIV;
        d     = 32'h00001234;
        s     = 32'h00000000;
        @(posedge clk_cog);
        #1;
        start = 1'b0;
        check("b2b.hold_r_lo", 64'(r_lo_o), 64'(42));
        check("b2b.done_low", 64'(done_o), 64'(0));
        wait_done(cyc, bcnt);
        check("b2b.latency", 64'(cyc), 64'(LAT_A));
        check_res("b2b", 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);

        // reset 20 cycles into an op: outputs cleared, op abandoned
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (20) @(posedge clk_cog);
        @(negedge clk_cog);
        nres = 1'b0;
        @(posedge clk_cog);
        #1;
        nres = 1'b1;
        check("midrst.busy", 64'(busy_o), 64'(0));
        check("midrst.done", 64'(done_o), 64'(0));
        check_res("midrst", '0, '0, 1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_cog);
            #1;
            if (done_o === 1'b1) dones++;
        end
        check("midrst.no_done", 64'(dones), 64'(0));
        run_op("after_rst", 1'b0, OP_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0);

`ifdef COG_MULDIV_SQRT_EN
        run_op("sqrt_17", 1'b0, OP_SQRT, 32'd17, 32'h0, 32'd4, 32'd1, 1'b0, 1'b0);
        run_op("sqrt_0",  1'b0, OP_SQRT, 32'd0,  32'h5, 32'd0, 32'd0, 1'b0, 1'b1);
`else
        run_op("op4_as_mul", 1'b0, OP_SQRT, 32'd17, 32'd3, 32'd51, 32'd0, 1'b0, 1'b0);
`endif

        // radix-4 instance
        run_op("r4_mul",  1'b1, OP_MUL,  32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
        run_op("r4_divs", 1'b1, OP_DIVS, 32'h80000000, 32'h00000003, 32'hD5555556, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("r4_muls", 1'b1, OP_MULS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
        run_op("r4_div0", 1'b1, OP_DIV,  32'h00000055, 32'h00000000, 32'hFFFFFFFF, 32'h00000055, 1'b1, 1'b0);
`ifdef COG_MULDIV_SQRT_EN
        run_op("r4_sqrt", 1'b1, OP_SQRT, 32'hFFFFFFFF, 32'h0, 32'h0000FFFF, 32'h0001FFFE, 1'b0, 1'b0);
`else
        run_op("r4_op4",  1'b1, OP_SQRT, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
